reg_file_16: RTL and testbench
==============================

Name: reg_file_16

Overview:
- 8-entry x 16-bit general-purpose register file for the 16-bit MIPS-style datapath.
- Sits directly upstream of the 16-bit 2:1 operand mux. rd_data_b feeds the mux "a" input; the sign-extended immediate feeds "b"; sel is ALUSrc.
- Two combinational read ports and one synchronous write port. R0 is hardwired to zero.
- Optional write-through bypass lets a same-cycle write be read in the decode stage.

Parameters:
- DATA_W, 16, register width in bits; must match the operand mux width.
- ADDR_W, 3, register address width; depth = 2**ADDR_W = 8.
- BYPASS, 1, 1 = read of the address being written this cycle returns wr_data; 0 = returns the stored (old) value.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable, sampled on the rising edge of clk.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  DATA_W  write data.
- rd_addr_a  input  ADDR_W  read port A index (rs).
- rd_addr_b  input  ADDR_W  read port B index (rt).
- rd_data_a  output  DATA_W  read port A data, combinational.
- rd_data_b  output  DATA_W  read port B data, combinational; drives operand mux input a.

Behaviour:
- Reset:
  - rst high at a rising edge clears all 8 registers to 16'h0000 on that edge.
  - rst has priority over we; a write presented in the reset cycle is discarded.
  - After reset, rd_data_a = rd_data_b = 16'h0000 for every address.
  - Reset asserted mid-operation clears everything on the next edge, regardless of pending writes.
- Write:
  - On a rising edge with rst=0, we=1 and wr_addr!=0: regs[wr_addr] <= wr_data.
  - Write latency: 1 cycle. The new value is visible on the reads from the cycle after the edge.
  - we=0: no register changes.
- R0:
  - Writes to address 0 are ignored; no storage is needed for R0.
  - Reads of address 0 always return 16'h0000, including under bypass.
- Read:
  - Purely combinational: rd_data_x = (rd_addr_x==0) ? 0 : regs[rd_addr_x].
  - No clock latency; an address change is reflected in the same cycle.
- Bypass:
  - BYPASS=1, we=1, wr_addr==rd_addr_x, wr_addr!=0: rd_data_x = wr_data in the same cycle, before the edge.
  - Both ports forward independently. If both ports address the written register, both return wr_data.
  - BYPASS=0: the old contents are returned until the edge.
  - Bypass is suppressed while rst=1; the reads show the stored contents.
- Simultaneous events:
  - Read A and read B of the same address return identical data.
  - A write and reads of a different address do not interact.
- Widths: no arithmetic. All data paths are exactly DATA_W bits with no extension or truncation.
- Unknowns: X on we while rst=0 is a protocol violation; the bench flags it with an assertion.

Decomposition:
- Shared package cpu16_pkg holds:
  - DATA_W = 16 and REG_ADDR_W = 3;
  - localparam REG_ZERO = 3'd0;
  - the typedef reg_addr_t (logic [2:0]) and word_t (logic [15:0]), reused by the operand mux, ALU and control.
- One natural sub-module: reg16_en, a DATA_W-bit register with synchronous active-high reset and write enable.
  - Instantiated 7 times (R1..R7).
  - A generate loop decodes wr_addr into the 7 enables.
- The read muxes and bypass compare stay in reg_file_16.

Test Plan:
1. Reset: preload R1..R7 with 16'hFFFF, assert rst for 1 cycle -> all 7 read back 16'h0000 on both ports the next cycle.
2. Write/read: we=1, wr_addr=3, wr_data=16'hA5C3 -> after the edge, rd_addr_a=3 gives 16'hA5C3 and rd_addr_b=3 gives 16'hA5C3; R2 stays 16'h0000.
3. R0 protection: we=1, wr_addr=0, wr_data=16'h1234 -> rd_data_a with rd_addr_a=0 reads 16'h0000, both before and after the edge.
4. Bypass: BYPASS=1, R5=16'h0001; same cycle we=1, wr_addr=5, wr_data=16'h7FFF, rd_addr_a=rd_addr_b=5 -> both read 16'h7FFF pre-edge. With BYPASS=0 both read 16'h0001 pre-edge and 16'h7FFF post-edge.
5. Reset vs write: rst=1 and we=1, wr_addr=6, wr_data=16'hBEEF on the same edge -> R6 reads 16'h0000 after the edge.
6. Integration with the operand mux: R4=16'h00F0, imm=16'hFF0F, rd_addr_b=4 -> mux out 16'h00F0 with sel=0 and 16'hFF0F with sel=1, in the same cycle.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit MIPS-style datapath
// (register file, operand mux, ALU and control).
package cpu16_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = 3'd0;

endpackage

// File: rtl/reg16_en.sv
// Single W-bit register with synchronous active-high reset and load enable.
// Reset takes priority over the enable.
module reg16_en
    import cpu16_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_file_16.sv
// 8 x DATA_W register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero, optional same-cycle write-through bypass.
module reg_file_16
    import cpu16_pkg::*;
#(
    parameter int DATA_W = cpu16_pkg::DATA_W,
    parameter int ADDR_W = cpu16_pkg::REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] reg_q [DEPTH];
    logic [DEPTH-1:0]  wr_en;

    // R0 has no storage; its slot in the read array is a constant zero.
    assign reg_q[0] = '0;
    assign wr_en[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_regs
            assign wr_en[gi] = we && (wr_addr == ADDR_W'(gi));

            reg16_en #(
                .W (DATA_W)
            ) u_reg (
                .clk  (clk),
                .rst  (rst),
                .en_i (wr_en[gi]),
                .d_i  (wr_data),
                .q_o  (reg_q[gi])
            );
        end
    endgenerate

    // Forwarding is only meaningful for a write that will actually land,
    // so it is blocked during reset and for the zero register.
    logic fwd_ok;
    assign fwd_ok = BYPASS && we && !rst && (wr_addr != ZERO_ADDR);

    always_comb begin
        rd_data_a = reg_q[rd_addr_a];
        if (rd_addr_a == ZERO_ADDR) begin
            rd_data_a = '0;
        end else if (fwd_ok && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = reg_q[rd_addr_b];
        if (rd_addr_b == ZERO_ADDR) begin
            rd_data_b = '0;
        end else if (fwd_ok && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: tb/tb_reg_file_16.sv
// Directed bench for reg_file_16: drives a bypass and a non-bypass instance
// in parallel and checks their read ports against a queue of expected words.
module tb_reg_file_16;
    import cpu16_pkg::*;

    localparam int P_A1  = 0;  // BYPASS=1 port A
    localparam int P_B1  = 1;  // BYPASS=1 port B
    localparam int P_A0  = 2;  // BYPASS=0 port A
    localparam int P_B0  = 3;  // BYPASS=0 port B
    localparam int P_MUX = 4;  // operand mux fed by BYPASS=1 port B

    logic      clk;
    logic      rst;
    logic      we;
    reg_addr_t wr_addr;
    word_t     wr_data;
    reg_addr_t rd_addr_a;
    reg_addr_t rd_addr_b;
    word_t     a1, b1, a0, b0;
    logic      sel;
    word_t     imm;
    word_t     mux_y;

    typedef struct {
        int    port;
        string tag;
        word_t exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    reg_file_16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (a1),
        .rd_data_b (b1)
    );

    reg_file_16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0)) dut_nb (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (a0),
        .rd_data_b (b0)
    );

    // Downstream 2:1 operand mux (ALUSrc).
    assign mux_y = sel ? imm : b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            assert (!$isunknown(we)) else $error("we is X/Z while rst is low");
        end
    end

    task automatic expect_word(input int port, input string tag, input word_t v);
        sb_entry_t e;
        e.port = port;
        e.tag  = tag;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        sb_entry_t e;
        word_t     obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                P_A1:    obs = a1;
                P_B1:    obs = b1;
                P_A0:    obs = a0;
                P_B0:    obs = b0;
                default: obs = mux_y;
            endcase
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
            $display("check %-14s port %0d observed %h expected %h", e.tag, e.port, obs, e.exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; sel = 1'b0; imm = '0;
        edge_step();
        edge_step();
        rst = 1'b0;

        // Reset state
        rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        #1;
        expect_word(P_A1, "rst_state_a", 16'h0000);
        expect_word(P_B1, "rst_state_b", 16'h0000);
        expect_word(P_A0, "rst_state_a0", 16'h0000);
        expect_word(P_B0, "rst_state_b0", 16'h0000);
        check_all();

        // Preload R1..R7 with all ones, then reset clears them
        for (int i = 1; i < 8; i++) begin
            we = 1'b1; wr_addr = 3'(i); wr_data = 16'hFFFF;
            edge_step();
        end
        we = 1'b0; rd_addr_a = 3'd1; rd_addr_b = 3'd7;
        #1;
        expect_word(P_A1, "preload_r1", 16'hFFFF);
        expect_word(P_B1, "preload_r7", 16'hFFFF);
        expect_word(P_A0, "preload_r1_nb", 16'hFFFF);
        check_all();
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        for (int i = 1; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i);
            #1;
            expect_word(P_A1, "reset_clr_a", 16'h0000);
            expect_word(P_B1, "reset_clr_b", 16'h0000);
            expect_word(P_A0, "reset_clr_a0", 16'h0000);
            expect_word(P_B0, "reset_clr_b0", 16'h0000);
            check_all();
        end

        // Write/read R3, R2 untouched
        we = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5C3; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        #1;
        expect_word(P_A1, "wr_other_a", 16'h0000);
        check_all();
        edge_step();
        we = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        #1;
        expect_word(P_A1, "wr_r3_a", 16'hA5C3);
        expect_word(P_B1, "wr_r3_b", 16'hA5C3);
        expect_word(P_A0, "wr_r3_a0", 16'hA5C3);
        expect_word(P_B0, "wr_r3_b0", 16'hA5C3);
        check_all();
        rd_addr_a = 3'd2;
        #1;
        expect_word(P_A1, "r2_unchanged", 16'h0000);
        check_all();

        // R0 protection, including under bypass
        we = 1'b1; wr_addr = 3'd0; wr_data = 16'h1234; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        #1;
        expect_word(P_A1, "r0_pre_a", 16'h0000);
        expect_word(P_B1, "r0_pre_b", 16'h0000);
        check_all();
        edge_step();
        we = 1'b0;
        #1;
        expect_word(P_A1, "r0_post_a", 16'h0000);
        expect_word(P_A0, "r0_post_a0", 16'h0000);
        check_all();

        // Bypass vs no bypass on R5
        we = 1'b1; wr_addr = 3'd5; wr_data = 16'h0001;
        edge_step();
        wr_data = 16'h7FFF; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        #1;
        expect_word(P_A1, "byp_pre_a", 16'h7FFF);
        expect_word(P_B1, "byp_pre_b", 16'h7FFF);
        expect_word(P_A0, "nobyp_pre_a", 16'h0001);
        expect_word(P_B0, "nobyp_pre_b", 16'h0001);
        check_all();
        edge_step();
        we = 1'b0;
        #1;
        expect_word(P_A1, "byp_post_a", 16'h7FFF);
        expect_word(P_B1, "byp_post_b", 16'h7FFF);
        expect_word(P_A0, "nobyp_post_a", 16'h7FFF);
        expect_word(P_B0, "nobyp_post_b", 16'h7FFF);
        check_all();

        // Forwarding on one port leaves the other port alone
        we = 1'b1; wr_addr = 3'd6; wr_data = 16'h1111; rd_addr_a = 3'd6; rd_addr_b = 3'd3;
        #1;
        expect_word(P_A1, "byp_indep_a", 16'h1111);
        expect_word(P_B1, "byp_indep_b", 16'hA5C3);
        expect_word(P_A0, "nobyp_indep_a", 16'h0000);
        check_all();
        edge_step();

        // Reset beats a simultaneous write; bypass suppressed during reset
        rst = 1'b1; we = 1'b1; wr_addr = 3'd6; wr_data = 16'hBEEF;
        #1;
        expect_word(P_A1, "rst_nobyp_a", 16'h1111);
        expect_word(P_B1, "rst_nobyp_b", 16'hA5C3);
        check_all();
        edge_step();
        rst = 1'b0; we = 1'b0;
        #1;
        expect_word(P_A1, "rst_vs_wr_a", 16'h0000);
        expect_word(P_A0, "rst_vs_wr_a0", 16'h0000);
        expect_word(P_B1, "rst_clr_r3", 16'h0000);
        check_all();

        // Operand mux integration
        we = 1'b1; wr_addr = 3'd4; wr_data = 16'h00F0;
        edge_step();
        we = 1'b0; rd_addr_b = 3'd4; imm = 16'hFF0F; sel = 1'b0;
        #1;
        expect_word(P_MUX, "mux_sel0", 16'h00F0);
        check_all();
        sel = 1'b1;
        #1;
        expect_word(P_MUX, "mux_sel1", 16'hFF0F);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
